id_reg_pipe_stage: RTL and testbench

// - Parametrised ID->REG pipeline register for an N-issue SPU front end; successor to the fixed dual-issue latch.
// - Carries LANES decoded-instruction bundles with a per-lane valid, a valid/ready handshake and a flush.
// - Uses a 2-entry skid buffer, so decode stalls by back-pressure with no bundle loss.
// - Sits between the dual instruction decoder and register-file read / hazard logic.

---
 rtl/spu_pipe_pkg.sv | 36 +++
 rtl/pipe_skid_buf.sv | 93 +++++++++
 rtl/id_reg_pipe_stage.sv | 69 ++++++
 tb/tb_id_reg_pipe_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_pipe_pkg.sv
// Shared types for the SPU front-end pipeline registers.
// Holds the decoded-lane payload, its field widths and the skid-buffer state encoding.
package spu_pipe_pkg;

    localparam int SPU_REG_ADDR_W = 7;   // 128-entry register file
    localparam int SPU_CTRL_W     = 7;   // execution control field
    localparam int IMM7_W         = 7;
    localparam int IMM10_W        = 10;
    localparam int IMM16_W        = 16;
    localparam int IMM18_W        = 18;

    // One decoded instruction as handed from ID to REG.
    typedef struct packed {
        logic                      reg_write_enable;
        logic                      source;
        logic [SPU_CTRL_W-1:0]     control;
        logic [SPU_REG_ADDR_W-1:0] ra;
        logic [SPU_REG_ADDR_W-1:0] rb;
        logic [SPU_REG_ADDR_W-1:0] rc;
        logic [SPU_REG_ADDR_W-1:0] rt;
        logic [IMM7_W-1:0]         imm7;
        logic [IMM10_W-1:0]        imm10;
        logic [IMM16_W-1:0]        imm16;
        logic [IMM18_W-1:0]        imm18;
    } id_lane_t;

    localparam int ID_LANE_W = $bits(id_lane_t);

    // Occupancy of a two-entry skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // main empty, skid empty
        ONE   = 2'd1,   // main full, skid empty
        TWO   = 2'd2    // main full, skid full
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry skid buffer with synchronous flush.
// in_ready is registered, so there is no combinational path from out_ready back to the producer;
// the second (skid) entry absorbs the bundle accepted in the cycle the consumer stalls.
module pipe_skid_buf
    import spu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             in_fire, out_fire;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    // Output is forced to zero when empty so stale data never leaks out, including during reset.
    assign out_data  = out_valid ? main_q : '0;
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    // Next-state and entry-update logic.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = TWO;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        in_ready_d = (state_d != TWO);
    end

    // State, entries and registered ready.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the data entries are reset too (not just the state) so every output reads 0 out of reset.
        if (!reset) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so all registers update together from the same old values.
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: rtl/id_reg_pipe_stage.sv
// ID->REG pipeline register for an N-issue SPU front end.
// Carries LANES decoded lanes plus per-lane valids through a two-entry skid buffer with flush.
// Bundles with no valid lane are accepted but not stored.
// Optional: define ID_REG_STALL_CNT_EN to add the saturating stall_cnt output.
module id_reg_pipe_stage
    import spu_pipe_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int REG_ADDR_W = 7,   // must agree with the package's id_lane_t
    parameter int CTRL_W     = 7    // must agree with the package's id_lane_t
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES-1:0]      in_lane_valid,
    input  id_lane_t [LANES-1:0]  in_lane,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_lane_valid,
    output id_lane_t [LANES-1:0]  out_lane
`ifdef ID_REG_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    // Lane width rebuilt from the parameters; if they disagree with the package the
    // flattened vector below no longer matches and the mismatch shows up at elaboration.
    localparam int LANE_W = 2 + CTRL_W + 4 * REG_ADDR_W + IMM7_W + IMM10_W + IMM16_W + IMM18_W;
    localparam int DATA_W = LANES * (LANE_W + 1);

    logic              store_valid;
    logic [DATA_W-1:0] buf_in_data;
    logic [DATA_W-1:0] buf_out_data;

    // An all-invalid bundle still handshakes (in_ready does not depend on in_valid) but is not stored.
    assign store_valid = in_valid & (|in_lane_valid);
    assign buf_in_data = {in_lane_valid, in_lane};

    pipe_skid_buf #(
        .WIDTH (DATA_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (store_valid),
        .in_ready  (in_ready),
        .in_data   (buf_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out_data)
    );

    assign {out_lane_valid, out_lane} = buf_out_data;

`ifdef ID_REG_STALL_CNT_EN
    // Saturating count of cycles the REG stage holds off a valid bundle; flush does not touch it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_reg_pipe_stage.sv
// Directed self-checking bench for id_reg_pipe_stage.
// Covers reset, single bundle, back-pressure into the skid entry, flush, empty/partial lane masks,
// asynchronous reset mid-stall and, with ID_REG_STALL_CNT_EN, the stall counter.
module tb_id_reg_pipe_stage;
    import spu_pipe_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_lane_valid;
    id_lane_t [1:0]       in_lane;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           out_lane_valid;
    id_lane_t [1:0]       out_lane;
`ifdef ID_REG_STALL_CNT_EN
    logic [31:0]          stall_cnt;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    id_lane_t [1:0] b1, ba, bb, bc, bd, be;

    always #5 clk = ~clk;

    id_reg_pipe_stage #(
        .LANES      (2),
        .REG_ADDR_W (7),
        .CTRL_W     (7)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_lane_valid  (in_lane_valid),
        .in_lane        (in_lane),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_lane_valid (out_lane_valid),
        .out_lane       (out_lane)
`ifdef ID_REG_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    function automatic id_lane_t mk_lane(input logic [6:0] rt, input logic [15:0] seed);
        id_lane_t l;
        l.reg_write_enable = 1'b1;
        l.source           = seed[0];
        l.control          = seed[6:0];
        l.ra               = seed[6:0] ^ 7'h11;
        l.rb               = seed[7:1];
        l.rc               = seed[13:7];
        l.rt               = rt;
        l.imm7             = seed[8:2];
        l.imm10            = seed[9:0] ^ 10'h2A5;
        l.imm16            = seed;
        l.imm18            = {seed, 2'b10};
        return l;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        b1[0] = mk_lane(7'd5,  16'h1234);
        b1[1] = mk_lane(7'd9,  16'hBEEF);
        ba[0] = mk_lane(7'd17, 16'hA0A1);
        ba[1] = mk_lane(7'd18, 16'hA2A3);
        bb[0] = mk_lane(7'd33, 16'hB0B1);
        bb[1] = mk_lane(7'd34, 16'hB2B3);
        bc[0] = mk_lane(7'd65, 16'hC0C1);
        bc[1] = mk_lane(7'd66, 16'hC2C3);
        bd[0] = mk_lane(7'd97, 16'hD0D1);
        bd[1] = mk_lane(7'd98, 16'hD2D3);
        be[0] = mk_lane(7'd120, 16'hE0E1);
        be[1] = mk_lane(7'd127, 16'hE2E3);

        reset         = 1'b0;
        in_valid      = 1'b0;
        in_lane_valid = 2'b00;
        in_lane       = '0;
        flush         = 1'b0;
        out_ready     = 1'b1;

        // Reset state
        #2;
        check("rst_in_ready", 256'(in_ready), 256'(1'b0));
        check("rst_out_valid", 256'(out_valid), 256'(1'b0));
        check("rst_out_lane_valid", 256'(out_lane_valid), 256'(2'b00));
        check("rst_out_lane", 256'(out_lane), 256'(0));
`ifdef ID_REG_STALL_CNT_EN
        check("rst_stall_cnt", 256'(stall_cnt), 256'(0));
`endif
        tick();
        tick();
        check("rst_in_ready_held", 256'(in_ready), 256'(1'b0));
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("post_rst_in_ready", 256'(in_ready), 256'(1'b1));
        check("post_rst_out_valid", 256'(out_valid), 256'(1'b0));

        // Single bundle, 1-cycle latency
        in_valid = 1'b1; in_lane = b1; in_lane_valid = 2'b11;
        tick();
        check("t1_out_valid", 256'(out_valid), 256'(1'b1));
        check("t1_out_lane_valid", 256'(out_lane_valid), 256'(2'b11));
        check("t1_out_lane", 256'(out_lane), 256'(b1));
        check("t1_rt0", 256'(out_lane[0].rt), 256'(7'd5));
        check("t1_rt1", 256'(out_lane[1].rt), 256'(7'd9));
        check("t1_in_ready", 256'(in_ready), 256'(1'b1));
        in_valid = 1'b0;
        tick();
        check("t1_drained", 256'(out_valid), 256'(1'b0));
        check("t1_drained_lv", 256'(out_lane_valid), 256'(2'b00));
        check("t1_in_ready2", 256'(in_ready), 256'(1'b1));

        // Back-pressure: A then B, then release
        out_ready = 1'b0;
        in_valid = 1'b1; in_lane = ba; in_lane_valid = 2'b11;
        tick();
        check("t2_a_out", 256'(out_lane), 256'(ba));
        check("t2_a_in_ready", 256'(in_ready), 256'(1'b1));
        in_lane = bb; in_lane_valid = 2'b01;
        tick();
        check("t2_hold_a", 256'(out_lane), 256'(ba));
        check("t2_hold_a_lv", 256'(out_lane_valid), 256'(2'b11));
        check("t2_full_in_ready", 256'(in_ready), 256'(1'b0));
        in_valid = 1'b0;
        tick();
        check("t2_still_a", 256'(out_lane), 256'(ba));
        check("t2_still_full", 256'(in_ready), 256'(1'b0));
        out_ready = 1'b1;
        tick();
        check("t2_b_valid", 256'(out_valid), 256'(1'b1));
        check("t2_b_out", 256'(out_lane), 256'(bb));
        check("t2_b_lv", 256'(out_lane_valid), 256'(2'b01));
        check("t2_b_in_ready", 256'(in_ready), 256'(1'b1));
        tick();
        check("t2_empty", 256'(out_valid), 256'(1'b0));

        // Flush in TWO with bundle C offered
        out_ready = 1'b0;
        in_valid = 1'b1; in_lane = ba; in_lane_valid = 2'b11;
        tick();
        in_lane = bb;
        tick();
        check("t3_full", 256'(in_ready), 256'(1'b0));
        flush = 1'b1; in_lane = bc;
        tick();
        check("t3_flush_out_valid", 256'(out_valid), 256'(1'b0));
        check("t3_flush_lv", 256'(out_lane_valid), 256'(2'b00));
        check("t3_flush_in_ready", 256'(in_ready), 256'(1'b1));
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("t3_no_c", 256'(out_valid), 256'(1'b0));

        // All-invalid bundle, then partial lane mask
        in_valid = 1'b1; in_lane = bd; in_lane_valid = 2'b00;
        tick();
        check("t4_empty_in_ready", 256'(in_ready), 256'(1'b1));
        check("t4_empty_out_valid", 256'(out_valid), 256'(1'b0));
        in_lane_valid = 2'b10;
        tick();
        check("t4_mask_out_valid", 256'(out_valid), 256'(1'b1));
        check("t4_mask_lv", 256'(out_lane_valid), 256'(2'b10));
        check("t4_mask_lane1", 256'(out_lane[1]), 256'(bd[1]));
        in_valid = 1'b0;
        tick();
        check("t4_drained", 256'(out_valid), 256'(1'b0));

        // Asynchronous reset mid-stall in TWO
        out_ready = 1'b0;
        in_valid = 1'b1; in_lane = ba; in_lane_valid = 2'b11;
        tick();
        in_lane = bb;
        tick();
        in_valid = 1'b0;
        check("t5_full", 256'(in_ready), 256'(1'b0));
        #2;
        reset = 1'b0;
        #1;
        check("t5_arst_out_valid", 256'(out_valid), 256'(1'b0));
        check("t5_arst_lv", 256'(out_lane_valid), 256'(2'b00));
        check("t5_arst_out_lane", 256'(out_lane), 256'(0));
        check("t5_arst_in_ready", 256'(in_ready), 256'(1'b0));
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("t5_resume_in_ready", 256'(in_ready), 256'(1'b1));
        check("t5_resume_out_valid", 256'(out_valid), 256'(1'b0));
        out_ready = 1'b1;
        in_valid = 1'b1; in_lane = be; in_lane_valid = 2'b11;
        tick();
        check("t5_e_valid", 256'(out_valid), 256'(1'b1));
        check("t5_e_out", 256'(out_lane), 256'(be));
        in_valid = 1'b0;
        tick();
        check("t5_e_drained", 256'(out_valid), 256'(1'b0));

`ifdef ID_REG_STALL_CNT_EN
        // Stall counter: 10 stalled cycles, then flush
        check("t6_cnt_zero", 256'(stall_cnt), 256'(0));
        out_ready = 1'b0;
        in_valid = 1'b1; in_lane = ba; in_lane_valid = 2'b11;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        check("t6_cnt_10", 256'(stall_cnt), 256'(10));
        check("t6_stalled_valid", 256'(out_valid), 256'(1'b1));
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0;
        check("t6_cnt_after_flush", 256'(stall_cnt), 256'(10));
        check("t6_flushed", 256'(out_valid), 256'(1'b0));
        tick();
        tick();
        check("t6_cnt_idle", 256'(stall_cnt), 256'(10));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
